// File: rtl/regfile_sb.sv
// regfile_sb: 31x N-bit integer register file (x0 reads zero) with a
// write-back scoreboard that stalls decode on RAW/WAW hazards.
// Ports: clk, rst_n (sync, active-low); wr_en/wr_addr/wr_data from
// write-back; rs1/rs2 addr/used in, rs1/rs2 data out (combinational);
// issue_valid/issue_we/issue_rd from decode; flush; hazard_stall out.
// Option: define RF_BYPASS_EN to forward same-cycle write-back data.
module regfile_sb #(
  parameter int N    = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  input  logic         rs1_used,
  input  logic         rs2_used,
  output logic [N-1:0] rs1_data,
  output logic [N-1:0] rs2_data,
  input  logic         issue_valid,
  input  logic         issue_we,
  input  logic [4:0]   issue_rd,
  input  logic         flush,
  output logic         hazard_stall
);

  logic [N-1:0]    regs [1:NREG-1];
  logic [NREG-1:1] busy_q;
  logic [NREG-1:0] busy_vec;

  logic wb_we;
  logic hit1;
  logic hit2;
  logic raw1;
  logic raw2;
  logic waw;
  logic issue_set;

  // x0 has no busy bit; pad a constant zero so lookups stay uniform
  assign busy_vec = {busy_q, 1'b0};

  assign wb_we = wr_en && (wr_addr != 5'd0);

`ifdef RF_BYPASS_EN
  assign hit1 = wb_we && (rs1_addr == wr_addr);
  assign hit2 = wb_we && (rs2_addr == wr_addr);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = hit1 ? wr_data : regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = hit2 ? wr_data : regs[rs2_addr];
    end
  end

  assign raw1 = rs1_used && (rs1_addr != 5'd0)
             && busy_vec[rs1_addr] && !hit1;
  assign raw2 = rs2_used && (rs2_addr != 5'd0)
             && busy_vec[rs2_addr] && !hit2;
  // one in-flight writer per register keeps clear/set unambiguous
  assign waw  = issue_we && (issue_rd != 5'd0)
             && busy_vec[issue_rd];

  assign hazard_stall = issue_valid && (raw1 || raw2 || waw);

  assign issue_set = issue_valid && issue_we
                  && (issue_rd != 5'd0)
                  && !hazard_stall && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wb_we) begin
        regs[wr_addr] <= wr_data;
      end
      if (flush) begin
        busy_q <= '0;
      end else begin
        if (wb_we) begin
          busy_q[wr_addr] <= 1'b0;
        end
        // younger issue wins over a same-register clear
        if (issue_set) begin
          busy_q[issue_rd] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb with an expected-value
// queue; works with or without RF_BYPASS_EN.
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_used;
  logic        rs2_used;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        hazard_stall;

  regfile_sb #(.N(32), .NREG(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_used(rs1_used),
    .rs2_used(rs2_used),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .issue_valid(issue_valid),
    .issue_we(issue_we),
    .issue_rd(issue_rd),
    .flush(flush),
    .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  errs    = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    vectors++;
    if (sb.size() == 0) begin
      errs++;
      $error("FAIL sb_empty: observed %h required queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errs++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
  endtask

  // busy[r] observed as a RAW stall from a non-writing issue
  task automatic probe(input string tag, input logic [4:0] r,
                       input logic exp_busy);
    idle();
    issue_valid = 1'b1;
    rs1_used    = 1'b1;
    rs1_addr    = r;
    expect_v(tag, {31'd0, exp_busy});
    settle();
    check({31'd0, hazard_stall});
    idle();
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = rd;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      expect_v("rst_rs1", 32'h0);
      expect_v("rst_rs2", 32'h0);
      expect_v("rst_stall", 32'h0);
      settle();
      check(rs1_data);
      check(rs2_data);
      check({31'd0, hazard_stall});
    end
    probe("rst_busy5", 5'd5, 1'b0);

    // write x5, same-cycle read depends on bypass
    wr_en    = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'hDEADBEEF;
    rs1_addr = 5'd5;
    expect_v("wr5_same", BYP ? 32'hDEADBEEF : 32'h0);
    settle();
    check(rs1_data);
    tick();
    idle();
    rs1_addr = 5'd5;
    expect_v("wr5_next", 32'hDEADBEEF);
    settle();
    check(rs1_data);

    // write x0 dropped, including same cycle
    wr_en    = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h1234;
    rs1_addr = 5'd0;
    expect_v("x0_same", 32'h0);
    settle();
    check(rs1_data);
    tick();
    idle();
    rs1_addr = 5'd0;
    rs2_addr = 5'd5;
    expect_v("x0_next", 32'h0);
    expect_v("x5_keep", 32'hDEADBEEF);
    settle();
    check(rs1_data);
    check(rs2_data);

    // RAW on x7
    issue(5'd7);
    expect_v("iss7_stall", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    tick();
    for (int k = 0; k < 2; k++) begin
      idle();
      issue_valid = 1'b1;
      rs2_addr    = 5'd7;
      rs2_used    = 1'b1;
      expect_v("raw7_stall", 32'h1);
      settle();
      check({31'd0, hazard_stall});
      tick();
    end
    idle();
    issue_valid = 1'b1;
    rs1_addr    = 5'd7;
    rs1_used    = 1'b0;
    expect_v("raw7_unused", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    rs1_addr = 5'd0;
    rs2_addr = 5'd7;
    rs2_used = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'h55;
    expect_v("wb7_stall", BYP ? 32'h0 : 32'h1);
    expect_v("wb7_data", BYP ? 32'h55 : 32'h0);
    settle();
    check({31'd0, hazard_stall});
    check(rs2_data);
    tick();
    wr_en = 1'b0;
    expect_v("post7_stall", 32'h0);
    expect_v("post7_data", 32'h55);
    settle();
    check({31'd0, hazard_stall});
    check(rs2_data);
    tick();

    // WAW on x9
    issue(5'd9);
    expect_v("iss9_a", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    tick();
    issue(5'd9);
    expect_v("waw9_a", 32'h1);
    settle();
    check({31'd0, hazard_stall});
    tick();
    expect_v("waw9_b", 32'h1);
    settle();
    check({31'd0, hazard_stall});
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hAA;
    expect_v("waw9_wb", 32'h1);
    settle();
    check({31'd0, hazard_stall});
    tick();
    wr_en = 1'b0;
    expect_v("waw9_go", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    tick();
    probe("busy9_set", 5'd9, 1'b1);

    // same-cycle write-back and issue of x3
    issue(5'd3);
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h333;
    expect_v("iss3_stall", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    tick();
    probe("busy3_set", 5'd3, 1'b1);
    rs2_addr = 5'd3;
    expect_v("reg3", 32'h333);
    settle();
    check(rs2_data);

    // flush
    issue(5'd4);
    tick();
    issue(5'd6);
    tick();
    issue(5'd8);
    flush = 1'b1;
    expect_v("flush_stall", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    tick();
    probe("fl_busy4", 5'd4, 1'b0);
    probe("fl_busy6", 5'd6, 1'b0);
    probe("fl_busy8", 5'd8, 1'b0);
    probe("fl_busy9", 5'd9, 1'b0);
    probe("fl_busy3", 5'd3, 1'b0);

    // reset mid-stall
    issue(5'd10);
    tick();
    idle();
    issue_valid = 1'b1;
    rs1_addr    = 5'd10;
    rs1_used    = 1'b1;
    expect_v("pre_rst_stall", 32'h1);
    settle();
    check({31'd0, hazard_stall});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_v("post_rst_stall", 32'h0);
    settle();
    check({31'd0, hazard_stall});
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd3;
    expect_v("post_rst_x5", 32'h0);
    expect_v("post_rst_x3", 32'h0);
    settle();
    check(rs1_data);
    check(rs2_data);
    rs1_addr = 5'd7;
    expect_v("post_rst_x7", 32'h0);
    settle();
    check(rs1_data);

    if (sb.size() != 0) begin
      errs++;
      $error("FAIL sb_left: observed %0d entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
